// File: rtl/sd_dat_tx_if.sv
// sd_dat_tx_if: command/storage-side bundle for sd_dat_tx
// SD_DAT_TX_BLKCNT_EN adds the blk_num pre-defined block count
interface sd_dat_tx_if;
  logic start, multi, widebus, stop;
  logic rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic sddatoe;
  logic [3:0] sddatout;
  logic busy, blk_done, underrun;
`ifdef SD_DAT_TX_BLKCNT_EN
  logic [15:0] blk_num;
  modport master(output start, multi, widebus, stop, rd_valid, rd_data, blk_num,
                 input rd_ready, sddatoe, sddatout, busy, blk_done, underrun);
  modport slave(input start, multi, widebus, stop, rd_valid, rd_data, blk_num,
                output rd_ready, sddatoe, sddatout, busy, blk_done, underrun);
`else
  modport master(output start, multi, widebus, stop, rd_valid, rd_data,
                 input rd_ready, sddatoe, sddatout, busy, blk_done, underrun);
  modport slave(input start, multi, widebus, stop, rd_valid, rd_data,
                output rd_ready, sddatoe, sddatout, busy, blk_done, underrun);
`endif
endinterface

// File: rtl/sd_dat_tx.sv
// sd_dat_tx: SD DAT[3:0] block transmitter (1/4-bit, per-lane CRC16, multi-block)
// SD_DAT_TX_BLKCNT_EN enables a pre-defined block count via blk_num
module sd_dat_tx #(
  parameter int BLOCK_BYTES = 512,
  parameter int WAIT_CYCLES = 2,
  parameter int GAP_CYCLES = 2
) (
  input logic sdclk,
  input logic rst,
  sd_dat_tx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HIZ, PRE, START, DATA, CRC, ENDB, GAP} state_t;
  localparam logic [15:0] LAST1 = 16'(BLOCK_BYTES * 8 - 1);
  localparam logic [15:0] LAST4 = 16'(BLOCK_BYTES * 2 - 1);
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  state_t r_state, w_state;
  logic [15:0] r_cnt, w_cnt, w_last, w_mask;
  logic [7:0] r_sh, w_sh, w_src, w_byte;
  logic [3:0][15:0] r_crc, w_crc;
  logic [3:0] r_dat, w_dat;
  logic r_multi, w_multi, r_wide, w_wide, r_ur, w_ur, r_done, w_done, r_rdy, w_rdy;
  logic r_oe, r_busy, w_blk_end;
`ifdef SD_DAT_TX_BLKCNT_EN
  logic [15:0] r_blk_num, w_blk_num, r_blk_cnt, w_blk_cnt;
  assign w_blk_end = !r_multi || (r_blk_num != 16'd0 && r_blk_cnt + 16'd1 == r_blk_num);
`else
  assign w_blk_end = !r_multi;
`endif
  assign w_last = r_wide ? LAST4 : LAST1;
  assign w_mask = r_wide ? 16'd1 : 16'd7;
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt + 16'd1;
    w_multi = r_multi;
    w_wide = r_wide;
    w_ur = r_ur | (r_rdy & ~bus.rd_valid);
    w_done = 1'b0;
`ifdef SD_DAT_TX_BLKCNT_EN
    w_blk_num = r_blk_num;
    w_blk_cnt = r_blk_cnt + {15'd0, r_state == ENDB && r_done};
`endif
    case (r_state)
      IDLE: if (bus.start && !bus.stop) begin
        w_state = HIZ;
        w_multi = bus.multi;
        w_wide = bus.widebus;
        w_ur = 1'b0;
`ifdef SD_DAT_TX_BLKCNT_EN
        w_blk_num = bus.blk_num;
        w_blk_cnt = '0;
`endif
      end
      HIZ: begin
        w_state = bus.stop ? IDLE : PRE;
        w_cnt = '0;
      end
      PRE: begin
        w_state = bus.stop ? IDLE : (r_cnt >= WAIT_LAST && bus.rd_valid) ? START : PRE;
        w_cnt = r_cnt >= WAIT_LAST ? r_cnt : r_cnt + 16'd1;
      end
      START: begin
        w_state = bus.stop ? ENDB : DATA;
        w_cnt = '0;
      end
      DATA: begin
        w_state = bus.stop ? ENDB : r_cnt == w_last ? CRC : DATA;
        w_cnt = r_cnt == w_last ? 16'd0 : r_cnt + 16'd1;
      end
      CRC: begin
        w_state = (bus.stop || r_cnt == 16'd15) ? ENDB : CRC;
        w_done = !bus.stop && r_cnt == 16'd15;
      end
      ENDB: begin
        // a zero blk_done here marks an aborted block
        w_state = (bus.stop || !r_done || w_blk_end) ? IDLE : GAP;
        w_cnt = '0;
      end
      GAP: begin
        w_state = bus.stop ? IDLE : r_cnt == GAP_LAST ? PRE : GAP;
        w_cnt = r_cnt == GAP_LAST ? 16'd0 : r_cnt + 16'd1;
      end
      default: w_state = IDLE;
    endcase
    w_byte = bus.rd_valid ? bus.rd_data : 8'hFF;
    w_src = r_rdy ? w_byte : r_sh;
    w_sh = r_sh;
    w_crc = r_crc;
    w_dat = 4'hF;
    if (w_state == START) begin
      w_dat = r_wide ? 4'h0 : 4'hE;
      w_crc = '0;
    end else if (w_state == DATA) begin
      w_dat = r_wide ? w_src[7:4] : {3'b111, w_src[7]};
      w_sh = r_wide ? {w_src[3:0], 4'hF} : {w_src[6:0], 1'b1};
      for (int l = 0; l < 4; l++)
        w_crc[l] = {r_crc[l][14:0], 1'b0} ^ ((r_crc[l][15] ^ w_dat[l]) ? 16'h1021 : 16'h0000);
    end else if (w_state == CRC) begin
      for (int l = 0; l < 4; l++) begin
        w_dat[l] = r_crc[l][15] | (!r_wide && l != 0);
        w_crc[l] = {r_crc[l][14:0], 1'b0};
      end
    end
    w_rdy = w_state == START || (w_state == DATA && (w_cnt & w_mask) == w_mask && w_cnt != w_last);
  end
  always_ff @(posedge sdclk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_sh <= '0;
      r_crc <= '0;
      r_dat <= 4'hF;
      r_oe <= 1'b0;
      r_busy <= 1'b0;
      r_rdy <= 1'b0;
      r_done <= 1'b0;
      r_ur <= 1'b0;
      r_multi <= 1'b0;
      r_wide <= 1'b0;
`ifdef SD_DAT_TX_BLKCNT_EN
      r_blk_num <= '0;
      r_blk_cnt <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_sh <= w_sh;
      r_crc <= w_crc;
      r_dat <= w_dat;
      r_oe <= w_state inside {PRE, START, DATA, CRC, ENDB};
      r_busy <= w_state != IDLE;
      r_rdy <= w_rdy;
      r_done <= w_done;
      r_ur <= w_ur;
      r_multi <= w_multi;
      r_wide <= w_wide;
`ifdef SD_DAT_TX_BLKCNT_EN
      r_blk_num <= w_blk_num;
      r_blk_cnt <= w_blk_cnt;
`endif
    end
  end
  assign bus.sddatoe = r_oe;
  assign bus.sddatout = r_dat;
  assign bus.rd_ready = r_rdy;
  assign bus.busy = r_busy;
  assign bus.blk_done = r_done;
  assign bus.underrun = r_ur;
endmodule

// File: tb/tb_sd_dat_tx.sv
// tb_sd_dat_tx: directed table-driven bench for sd_dat_tx with a cycle log of DAT activity
module tb_sd_dat_tx;
  logic sdclk = 1'b0;
  logic rst = 1'b1;
  always #5 sdclk = ~sdclk;
  sd_dat_tx_if bus();
  sd_dat_tx dut (.sdclk(sdclk), .rst(rst), .bus(bus));
  typedef struct {bit wide; bit ff; int start_off; int end_off; int crc0;} vec_t;
  int total = 0, bad = 0, cyc = 0, src_idx = 0, src_base = 0;
  bit pat_ff = 1'b0;
  logic [6:0] lg [0:65535];
  logic [7:0] exp_b [0:511];
  assign bus.rd_data = pat_ff ? 8'hFF : 8'(src_idx - src_base);
  always @(posedge sdclk) begin
    cyc <= cyc + 1;
    if (bus.rd_ready && bus.rd_valid) src_idx <= src_idx + 1;
  end
  // per-cycle record: {busy, blk_done, oe, dat}
  always @(negedge sdclk) if (cyc < 65536) lg[cyc] <= {bus.busy, bus.blk_done, bus.sddatoe, bus.sddatout};
  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic d);
    return {c[14:0], 1'b0} ^ ((c[15] ^ d) ? 16'h1021 : 16'h0000);
  endfunction
  function automatic int find_start(input int a, input int b);
    for (int c = a; c < b; c++) if (lg[c][4] === 1'b1 && lg[c][0] === 1'b0) return c;
    return -1;
  endfunction
  function automatic logic [15:0] lane_word(input int a, input int l);
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++) w = {w[14:0], lg[a + i][l]};
    return w;
  endfunction
  function automatic int count_done(input int a, input int b);
    int n = 0;
    for (int c = a; c < b; c++) if (lg[c][5] === 1'b1) n++;
    return n;
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge sdclk);
    #1;
  endtask
  task automatic go(input bit m, input bit w, output int c0);
    bus.multi = m;
    bus.widebus = w;
    bus.start = 1'b1;
    c0 = cyc;
    tick(1);
    bus.start = 1'b0;
    bus.multi = 1'b0;
    bus.widebus = 1'b0;
  endtask
  task automatic wait_idle(input string n, input int budget);
    int k = 0;
    while (bus.busy && k < budget) begin
      tick(1);
      k++;
    end
    if (bus.busy) begin
      total++;
      bad++;
      $display("FAIL %s: busy still 1 after %0d cycles, want 0", n, budget);
    end
  endtask
  task automatic wait_src(input string n, input int target, input int budget);
    int k = 0;
    while (src_idx - src_base < target && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) begin
      total++;
      bad++;
      $display("FAIL %s: got %0d bytes want %0d", n, src_idx - src_base, target);
    end
  endtask
  task automatic check_block(input string n, input int s, input bit w, input int e);
    logic [15:0] crc [4];
    int d, errs, c, l;
    d = e - 17;
    errs = 0;
    for (int k = 0; k < 4; k++) crc[k] = '0;
    chk({n, " sbit"}, int'(lg[s][4:0]), w ? 'h10 : 'h1E);
    for (int j = 0; j < 512; j++)
      for (int b = 7; b >= 0; b--) begin
        c = w ? s + 1 + 2 * j + (b >= 4 ? 0 : 1) : s + 1 + 8 * j + 7 - b;
        l = w ? b % 4 : 0;
        if (lg[c][4] !== 1'b1 || lg[c][l] !== exp_b[j][b] || (!w && lg[c][3:1] !== 3'b111)) errs++;
        crc[l] = crc_bit(crc[l], exp_b[j][b]);
      end
    chk({n, " data"}, errs, 0);
    for (int k = 0; k < (w ? 4 : 1); k++)
      chk($sformatf("%s crc%0d", n, k), int'(lane_word(s + d + 1, k)), int'(crc[k]));
    chk({n, " end"}, int'(lg[s + e]), 'h7F);
    chk({n, " oe off"}, int'(lg[s + e + 1][4]), 0);
  endtask
  initial begin
    vec_t tv [4];
    int c0, s, s2, sc, vc, errs, n;
    tv[0] = '{0, 1, 4, 4113, 'h7FA1};
    tv[1] = '{1, 0, 4, 1041, -1};
    tv[2] = '{1, 1, 4, 1041, -1};
    tv[3] = '{0, 0, 4, 4113, -1};
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.multi = 1'b0;
    bus.widebus = 1'b0;
    bus.rd_valid = 1'b1;
`ifdef SD_DAT_TX_BLKCNT_EN
    bus.blk_num = 16'd0;
`endif
    tick(3);
    chk("reset", int'({bus.sddatoe, bus.sddatout, bus.rd_ready, bus.busy, bus.blk_done, bus.underrun}), 'h0F0);
    rst = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      pat_ff = tv[i].ff;
      src_base = src_idx;
      for (int j = 0; j < 512; j++) exp_b[j] = tv[i].ff ? 8'hFF : 8'(j);
      go(1'b0, tv[i].wide, c0);
      wait_idle($sformatf("v%0d idle", i), 5000);
      tick(2);
      s = find_start(c0, c0 + 60);
      chk($sformatf("v%0d start", i), s - c0, tv[i].start_off);
      if (s < 0) s = c0;
      check_block($sformatf("v%0d", i), s, tv[i].wide, tv[i].end_off);
      if (tv[i].crc0 >= 0) chk($sformatf("v%0d crc0 const", i), int'(lane_word(s + tv[i].end_off - 16, 0)), tv[i].crc0);
      chk($sformatf("v%0d busy fall", i), int'(lg[s + tv[i].end_off + 1][6]), 0);
      chk($sformatf("v%0d consumed", i), src_idx - src_base, 512);
      chk($sformatf("v%0d dones", i), count_done(c0, cyc), 1);
    end
    pat_ff = 1'b0;
    src_base = src_idx;
    for (int j = 0; j < 512; j++) exp_b[j] = 8'(j);
    go(1'b1, 1'b0, c0);
    wait_src("multi bytes", 1124, 20000);
    bus.stop = 1'b1;
    sc = cyc;
    tick(1);
    bus.stop = 1'b0;
    wait_idle("multi idle", 100);
    tick(2);
    n = src_idx - src_base;
    chk("multi consumed 1124/1125", int'(n == 1124 || n == 1125), 1);
    chk("multi dones", count_done(c0, cyc), 2);
    chk("multi endb", int'(lg[sc + 1]), 'h5F);
    chk("multi after endb", int'(lg[sc + 2][6:4]), 0);
    s = find_start(c0, c0 + 60);
    if (s < 0) s = c0;
    check_block("m1", s, 1'b0, 4113);
    chk("m1 gap oe", int'(lg[s + 4114][4]), 0);
    chk("m1 pre", int'(lg[s + 4116][4:0]), 'h1F);
    s2 = find_start(s + 4114, s + 4200);
    chk("m2 offset", s2 - s, 4118);
    if (s2 < 0) s2 = s;
    check_block("m2", s2, 1'b0, 4113);
    src_base = src_idx;
    for (int j = 0; j < 512; j++) exp_b[j] = j < 10 ? 8'(j) : j < 12 ? 8'hFF : 8'(j - 2);
    go(1'b0, 1'b0, c0);
    wait_src("ur bytes", 10, 1000);
    bus.rd_valid = 1'b0;
    tick(20);
    bus.rd_valid = 1'b1;
    tick(10);
    chk("ur mid", int'(bus.underrun), 1);
    wait_idle("ur idle", 5000);
    tick(2);
    s = find_start(c0, c0 + 60);
    chk("ur start", s - c0, 4);
    if (s < 0) s = c0;
    check_block("ur", s, 1'b0, 4113);
    tick(20);
    chk("ur sticky", int'(bus.underrun), 1);
    chk("ur consumed", src_idx - src_base, 510);
    bus.rd_valid = 1'b0;
    go(1'b0, 1'b0, c0);
    chk("ur cleared by start", int'(bus.underrun), 0);
    tick(49);
    vc = cyc;
    bus.rd_valid = 1'b1;
    tick(3);
    errs = 0;
    for (int c = c0 + 2; c <= vc; c++) if (lg[c][4:0] !== 5'h1F) errs++;
    chk("stall pre", errs, 0);
    chk("stall start", find_start(c0, vc + 3) - vc, 1);
    tick(100);
    rst = 1'b1;
    tick(1);
    chk("rst mid", int'({bus.sddatoe, bus.busy, bus.sddatout, bus.rd_ready}), 'h1E);
    rst = 1'b0;
    tick(2);
    bus.start = 1'b1;
    bus.stop = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    chk("start+stop", int'(bus.busy), 0);
    go(1'b0, 1'b0, c0);
    tick(1);
    chk("pre oe", int'(bus.sddatoe), 1);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    chk("stop in pre", int'({bus.busy, bus.sddatoe}), 0);
`ifdef SD_DAT_TX_BLKCNT_EN
    bus.blk_num = 16'd2;
    src_base = src_idx;
    go(1'b1, 1'b1, c0);
    wait_idle("blkcnt idle", 5000);
    tick(2);
    chk("blkcnt dones", count_done(c0, cyc), 2);
    chk("blkcnt consumed", src_idx - src_base, 1024);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sd_dat_tx.md
Name: sd_dat_tx

Overview:
- Parametrised SD-card data-line transmitter for the card-emulator side: streams blocks from a byte source onto DAT[3:0].
- Supports 1-bit and 4-bit bus modes, configurable block length, and single- or open-ended multi-block reads.
- Computes an independent CRC16 per active DAT lane, as the SD physical spec requires.
- Sits between the command engine (start/stop/mode controls) and the storage reader (valid/ready byte stream).

Parameters:
- BLOCK_BYTES, 512: bytes per data block; range 8..4096, must be even.
- WAIT_CYCLES, 2: minimum cycles DAT is driven 0xF before the start bit (Nac). Must be ≥1.
- GAP_CYCLES, 2: cycles DAT is released between blocks in multi-block mode. Must be ≥1.

Ports:
- sdclk  in  1  SD clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin a read sequence. Ignored while busy=1.
- multi  in  1  sampled with start; 1 = repeat blocks until stop.
- widebus  in  1  sampled with start; 0 = 1-bit mode, 1 = 4-bit mode.
- stop  in  1  pulse: abort or terminate the sequence (CMD12).
- rd_valid  in  1  byte source has data.
- rd_data  in  8  byte from the source.
- rd_ready  out  1  byte consumed this cycle when rd_valid=1.
- sddatoe  out  1  DAT output enable.
- sddatout  out  4  DAT output value.
- busy  out  1  high in every state except IDLE.
- blk_done  out  1  one-cycle pulse on each END-bit cycle of a complete block.
- underrun  out  1  sticky: source was not valid when a byte was required. Cleared only by start or rst.

Behaviour:
- Reset values: sddatoe=0, sddatout=4'hF, rd_ready=0, busy=0, blk_done=0, underrun=0. FSM goes to IDLE; CRCs and counters clear.
- All outputs are registered.
- FSM states: IDLE, HIZ, PRE, START, DATA, CRC, ENDB, GAP.
  - IDLE: oe=0, dat=F. On start (with stop=0): latch multi and widebus, clear underrun, go to HIZ.
  - HIZ: 1 cycle, oe=0, dat=F.
  - PRE: oe=1, dat=F. Stays at least WAIT_CYCLES cycles, then holds until rd_valid=1, then goes to START.
  - START: oe=1. Drives 0 on active lanes; inactive lanes drive 1 in 1-bit mode. rd_ready=1 captures the first byte. Lane CRCs clear to 0.
  - DATA: BLOCK_BYTES*8 cycles in 1-bit mode, BLOCK_BYTES*2 cycles in 4-bit mode.
    - 1-bit: byte is MSB first on DAT0; DAT[3:1]=1.
    - 4-bit: high nibble then low nibble; DAT3 carries bit7/bit3.
    - rd_ready=1 on the last cycle of every byte except the final byte of the block.
    - If rd_valid=0 when a byte is captured: set underrun, substitute 0xFF, keep the bit timing.
  - CRC: 16 cycles. Each active lane shifts out its own CRC16 MSB first. Inactive lanes drive 1.
  - ENDB: 1 cycle, dat=F, oe=1, blk_done=1. Then go to GAP if multi=1, otherwise IDLE.
  - GAP: oe=0 for GAP_CYCLES cycles, then go to PRE.
- CRC16: polynomial x^16+x^12+x^5+1, initial value 0. Update each cycle on each active lane's transmitted data bit; start and end bits are excluded.
- Cycles per block, start through end bit: 4114 in 1-bit mode; 1042 in 4-bit mode (BLOCK_BYTES=512).
- stop handling:
  - In START, DATA or CRC: next cycle is ENDB with blk_done=0, then IDLE.
  - In HIZ, PRE or GAP: next state is IDLE.
  - stop and start in the same cycle: stop wins, the block stays IDLE.
- rd_ready is never asserted outside START/DATA, so the source never has bytes over-consumed.
- rst mid-transfer: all outputs return to reset values on the next edge; no end bit is driven.

Optional Feature:
- SD_DAT_TX_BLKCNT_EN defined:
  - Extra input blk_num[15:0], latched with start.
  - If multi=1 and blk_num≠0: after blk_num completed blocks, ENDB goes to IDLE instead of GAP (pre-defined block count, CMD23).
  - blk_num=0 means open-ended.
- Not defined: no blk_num port; multi-block runs until stop.

Test Plan:
- 1-bit single block, source always valid with 512×0xFF, WAIT_CYCLES=2:
  - Start bit at cycle 4 after the start pulse.
  - DAT0 CRC = 0x7FA1.
  - End bit at cycle 4+4113.
  - blk_done pulses once, busy falls after ENDB.
- 4-bit single block, bytes = index mod 256:
  - Nibble order matches the spec.
  - Each lane's CRC equals a bench model computing CRC16 per lane.
  - Block length is 1042 driven cycles.
- Multi-block, 1-bit, 3 blocks, stop asserted at byte 100 of block 3:
  - Two blk_done pulses.
  - An ENDB (dat=F) cycle follows stop, then IDLE.
  - Exactly 2×512+100 or 101 bytes consumed.
- Underrun: drop rd_valid for 20 cycles at byte 10 in 1-bit mode:
  - Byte 10 is sent as 0xFF.
  - underrun=1 and stays 1 until the next start.
  - Block length is unchanged.
- Initial stall: rd_valid low for 50 cycles after start:
  - PRE holds dat=F, oe=1 throughout.
  - Start bit appears the cycle after rd_valid rises.
  - rst asserted mid-DATA gives oe=0, busy=0 on the next edge.
- SD_DAT_TX_BLKCNT_EN with blk_num=2, multi=1: exactly 2 blocks are sent, then IDLE with no stop.
